// File: rtl/fpnorm_pkg.sv
// Shared FPU definitions: normalization sequencer state encodings, exponent
// limits and small helpers used across the FPU mantissa/exponent modules.
package fpnorm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RSH  = 3'd1,
        ST_NORM = 3'd2,
        ST_UFLO = 3'd3,
        ST_DONE = 3'd4
    } norm_state_t;

    localparam logic signed [7:0] EXP_MAX = 8'sh7F;
    localparam logic signed [7:0] EXP_MIN = 8'sh80;

    // Two's-complement mantissa is normalized when sign and next bit differ.
    function automatic logic is_normalized(input logic b0, input logic b1);
        return b0 ^ b1;
    endfunction

endpackage

// File: rtl/fpexp.sv
// Exponent register for the normalization sequencer: load, saturating-free
// increment/decrement (guarded at the limits) and limit flags.
module fpexp
    import fpnorm_pkg::*;
#(
    parameter int EBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic [EBITS-1:0] i_din,
    output logic [EBITS-1:0] o_exp,
    output logic             o_at_max,
    output logic             o_at_min
);

    localparam logic [EBITS-1:0] EMAX = {1'b0, {(EBITS-1){1'b1}}};
    localparam logic [EBITS-1:0] EMIN = {1'b1, {(EBITS-1){1'b0}}};
    localparam logic [EBITS-1:0] EONE = {{(EBITS-1){1'b0}}, 1'b1};

    logic [EBITS-1:0] r_exp;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = (r_exp == EMAX);
    assign w_at_min = (r_exp == EMIN);

    // Exponent register; the limit guards make wraparound impossible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp <= '0;
        end else if (i_clr) begin
            r_exp <= '0;
        end else if (i_load) begin
            r_exp <= i_din;
        end else if (i_inc && !w_at_max) begin
            r_exp <= r_exp + EONE;
        end else if (i_dec && !w_at_min) begin
            r_exp <= r_exp - EONE;
        end else begin
            r_exp <= r_exp;
        end
    end

    assign o_exp    = r_exp;
    assign o_at_max = w_at_max;
    assign o_at_min = w_at_min;

endmodule

// File: rtl/fpnorm.sv
// Normalization sequencer: steps the T register one bit per clock until the
// mantissa is normalized, tracking the exponent and reporting zero/of/uf.
module fpnorm
    import fpnorm_pkg::*;
#(
    parameter int MBITS = 40,
    parameter int EBITS = 8
) (
    input  logic             clk_sys,
    input  logic             clr_,
    input  logic             start,
    input  logic             ovf,
    input  logic [EBITS-1:0] exp_in,
    input  logic             t0,
    input  logic             t1,
    input  logic             t_zero,
    output logic             shl,
    output logic             shr,
    output logic             t_1,
    output logic             t_clr,
    output logic [EBITS-1:0] exp_out,
    output logic [5:0]       nsh,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             of,
    output logic             uf
);

    localparam logic [5:0] NSH_LIMIT = 6'(MBITS - 1);

    norm_state_t r_state;
    norm_state_t w_state_nx;
    logic [5:0]  r_nsh;
    logic        r_zero;
    logic        r_of;
    logic        r_uf;

    logic        w_shl;
    logic        w_shr;
    logic        w_tclr;
    logic        w_exp_load;
    logic        w_exp_inc;
    logic        w_exp_dec;
    logic        w_exp_clr;
    logic        w_nsh_inc;
    logic        w_accept;
    logic        w_set_zero;
    logic        w_set_of;
    logic        w_set_uf;
    logic        w_at_max;
    logic        w_at_min;

    fpexp #(
        .EBITS(EBITS)
    ) u_fpexp (
        .clk     (clk_sys),
        .rst_n   (clr_),
        .i_clr   (w_exp_clr),
        .i_load  (w_exp_load),
        .i_inc   (w_exp_inc),
        .i_dec   (w_exp_dec),
        .i_din   (exp_in),
        .o_exp   (exp_out),
        .o_at_max(w_at_max),
        .o_at_min(w_at_min)
    );

    // State register.
    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and per-cycle shift/exponent controls.
    always_comb begin
        w_state_nx = r_state;
        w_shl      = 1'b0;
        w_shr      = 1'b0;
        w_tclr     = 1'b0;
        w_exp_load = 1'b0;
        w_exp_inc  = 1'b0;
        w_exp_dec  = 1'b0;
        w_exp_clr  = 1'b0;
        w_nsh_inc  = 1'b0;
        w_accept   = 1'b0;
        w_set_zero = 1'b0;
        w_set_of   = 1'b0;
        w_set_uf   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept   = 1'b1;
                    w_exp_load = 1'b1;
                    w_state_nx = ovf ? ST_RSH : ST_NORM;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RSH: begin
                if (w_at_max) begin
                    w_set_of   = 1'b1;
                    w_state_nx = ST_DONE;
                end else begin
                    w_shr      = 1'b1;
                    w_exp_inc  = 1'b1;
                    w_state_nx = ST_NORM;
                end
            end
            ST_NORM: begin
                if (t_zero) begin
                    w_exp_clr  = 1'b1;
                    w_set_zero = 1'b1;
                    w_state_nx = ST_DONE;
                end else if (is_normalized(t0, t1)) begin
                    w_state_nx = ST_DONE;
                end else if (w_at_min) begin
                    w_state_nx = ST_UFLO;
                end else if (r_nsh == NSH_LIMIT) begin
                    // Unreachable with a consistent datapath; bounds the loop anyway.
                    w_state_nx = ST_DONE;
                end else begin
                    w_shl      = 1'b1;
                    w_exp_dec  = 1'b1;
                    w_nsh_inc  = 1'b1;
                    w_state_nx = ST_NORM;
                end
            end
            ST_UFLO: begin
                w_tclr     = 1'b1;
                w_exp_clr  = 1'b1;
                w_set_uf   = 1'b1;
                w_set_zero = 1'b1;
                w_state_nx = ST_DONE;
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Left-shift counter for the current operation.
    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            r_nsh <= 6'd0;
        end else if (w_accept) begin
            r_nsh <= 6'd0;
        end else if (w_nsh_inc) begin
            r_nsh <= r_nsh + 6'd1;
        end else begin
            r_nsh <= r_nsh;
        end
    end

    // Result flags: cleared on an accepted start, held until the next one.
    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            r_zero <= 1'b0;
            r_of   <= 1'b0;
            r_uf   <= 1'b0;
        end else if (w_accept) begin
            r_zero <= 1'b0;
            r_of   <= 1'b0;
            r_uf   <= 1'b0;
        end else begin
            r_zero <= r_zero | w_set_zero;
            r_of   <= r_of | w_set_of;
            r_uf   <= r_uf | w_set_uf;
        end
    end

    assign shl   = w_shl;
    assign shr   = w_shr;
    assign t_1   = w_shr & ~t0;
    assign t_clr = w_tclr;
    assign nsh   = r_nsh;
    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign zero  = r_zero;
    assign of    = r_of;
    assign uf    = r_uf;

endmodule
